// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port RAM.
// Each transaction is IDLE -> ACCESS -> RESP: one grant pulse in ACCESS, one
// response pulse in RESP, so one transaction completes every three cycles.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   pN_req/we/addr/wdata requester N (N=0,1) request, held until pN_gnt
//   pN_gnt              one-cycle accept pulse (ACCESS cycle)
//   pN_rvalid           one-cycle completion pulse (RESP cycle)
//   pN_rdata, pN_err    read data / out-of-range flag, qualified by pN_rvalid
//   ram_*               single-port RAM interface, combinational read data
//   busy                high whenever the FSM is not idle
module ram_arbiter #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  localparam logic [31:0] DepthW = 32'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q;
  logic                owner_q;  // port that owns the in-flight transaction
  logic                last_q;   // port granted most recently
  logic                we_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                win_d;
  logic                in_range;
  logic                access;
  logic                resp;

  // Contention goes to the port not granted last; otherwise the sole requester.
  always_comb begin
    win_d = (p0_req && p1_req) ? ~last_q : ~p0_req;
  end

  assign in_range = (addr_q < DepthW);
  assign access   = (state_q == StAccess);
  assign resp     = (state_q == StResp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (p0_req || p1_req) begin
            state_q <= StAccess;
            owner_q <= win_d;
            last_q  <= win_d;
            we_q    <= win_d ? p1_we    : p0_we;
            addr_q  <= win_d ? p1_addr  : p0_addr;
            wdata_q <= win_d ? p1_wdata : p0_wdata;
          end
        end
        StAccess: begin
          state_q <= StResp;
          rdata_q <= (in_range && !we_q) ? ram_data_out : '0;
          err_q   <= ~in_range;
        end
        StResp: begin
          state_q <= StIdle;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    p0_gnt           = access && !owner_q;
    p1_gnt           = access && owner_q;
    p0_rvalid        = resp && !owner_q;
    p1_rvalid        = resp && owner_q;
    p0_rdata         = p0_rvalid ? rdata_q : '0;
    p1_rdata         = p1_rvalid ? rdata_q : '0;
    p0_err           = p0_rvalid && err_q;
    p1_err           = p1_rvalid && err_q;
    ram_read_enable  = access && in_range && !we_q;
    // Gate with reset so a reset edge inside ACCESS can never commit a write.
    ram_write_enable = access && in_range && we_q && reset;
    ram_addr         = (access && in_range) ? addr_q : '0;
    ram_data_in      = (access && in_range && we_q) ? wdata_q : '0;
    busy             = (state_q != StIdle);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req = '0;
  logic [1:0]  we  = '0;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] ram_addr, ram_data_in, ram_data_out;
  logic        ram_read_enable, ram_write_enable, busy;

  ram_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .p0_req           (req[0]),
    .p0_we            (we[0]),
    .p0_addr          (addr[0]),
    .p0_wdata         (wdata[0]),
    .p0_gnt           (p0_gnt),
    .p0_rvalid        (p0_rvalid),
    .p0_rdata         (p0_rdata),
    .p0_err           (p0_err),
    .p1_req           (req[1]),
    .p1_we            (we[1]),
    .p1_addr          (addr[1]),
    .p1_wdata         (wdata[1]),
    .p1_gnt           (p1_gnt),
    .p1_rvalid        (p1_rvalid),
    .p1_rdata         (p1_rdata),
    .p1_err           (p1_err),
    .ram_addr         (ram_addr),
    .ram_data_in      (ram_data_in),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out),
    .busy             (busy)
  );

  // RAM model: combinational read, posedge write, index truncated to 10 bits
  // so a stray out-of-range write would alias onto a real word.
  logic [31:0] mem [DEPTH];
  assign ram_data_out = (ram_addr < DEPTH) ? mem[ram_addr[9:0]] : 32'hBAD0_BAD0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 32'h0000_1234;
    mem[3] = 32'h3333_3333;
    mem[9] = 32'h0000_0099;
    forever begin
      @(posedge clk);
      if (ram_write_enable) mem[ram_addr[9:0]] = ram_data_in;
    end
  end

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q0 [$];  // {err, rdata}
  logic [32:0] exp_q1 [$];
  int          exp_gnt [$];
  logic [32:0] e0, e1;
  int          g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic port_gnt(input int p);
    return (p == 0) ? p0_gnt : p1_gnt;
  endfunction

  function automatic logic port_rvalid(input int p);
    return (p == 0) ? p0_rvalid : p1_rvalid;
  endfunction

  // Response/grant monitor: pops expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (reset) begin
      if (p0_rvalid) begin
        if (exp_q0.size() == 0) chk("p0_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e0 = exp_q0.pop_front();
          chk("p0_rdata", p0_rdata, e0[31:0]);
          chk("p0_err", {31'b0, p0_err}, {31'b0, e0[32]});
        end
      end else chk("p0_quiet", p0_rdata | {31'b0, p0_err}, 32'd0);
      if (p1_rvalid) begin
        if (exp_q1.size() == 0) chk("p1_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e1 = exp_q1.pop_front();
          chk("p1_rdata", p1_rdata, e1[31:0]);
          chk("p1_err", {31'b0, p1_err}, {31'b0, e1[32]});
        end
      end else chk("p1_quiet", p1_rdata | {31'b0, p1_err}, 32'd0);
      if (p0_gnt || p1_gnt) begin
        if (exp_gnt.size() == 0) chk("unexpected_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd0);
        else begin
          g = exp_gnt.pop_front();
          chk("gnt_order", {30'b0, p1_gnt, p0_gnt}, (g == 0) ? 32'd1 : 32'd2);
        end
      end
    end
  end

  // One transaction from an idle arbiter; optional one-cycle p1 pulse in RESP.
  task automatic do_txn(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input bit pulse_p1);
    int  n = 0;
    logic in_r;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_txn", {31'b0, busy}, 32'd0);
    we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    exp_gnt.push_back(p);
    if (p == 0) exp_q0.push_back({ee, er});
    else        exp_q1.push_back({ee, er});
    @(negedge clk);
    chk("gnt_latency", {31'b0, port_gnt(p)}, 32'd1);
    in_r = (a < DEPTH);
    chk("ram_we", {31'b0, ram_write_enable}, {31'b0, w && in_r});
    chk("ram_re", {31'b0, ram_read_enable}, {31'b0, !w && in_r});
    if (in_r) chk("ram_addr", ram_addr, a);
    if (in_r && w) chk("ram_data_in", ram_data_in, d);
    req[p] = 1'b0;
    @(negedge clk);
    chk("rvalid_latency", {31'b0, port_rvalid(p)}, 32'd1);
    if (pulse_p1) begin
      we[1] = 1'b0; addr[1] = 32'd0; req[1] = 1'b1;
      @(negedge clk);
      req[1] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int grants;
    int n;
    int p1_seen;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd0);
    chk("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("rst_ram_en", {30'b0, ram_write_enable, ram_read_enable}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);

    // Both ports reading from reset release: grants alternate p0,p1,p0,p1
    we = 2'b00; addr[0] = 32'd3; addr[1] = 32'd9; req = 2'b11;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_q0.push_back({1'b0, 32'h3333_3333}); exp_q0.push_back({1'b0, 32'h3333_3333});
    exp_q1.push_back({1'b0, 32'h0000_0099}); exp_q1.push_back({1'b0, 32'h0000_0099});
    reset = 1'b1;
    @(negedge clk);
    chk("first_gnt_after_reset", {31'b0, p0_gnt}, 32'd1);
    grants = (p0_gnt || p1_gnt) ? 1 : 0;
    n = 0;
    while (grants < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (p0_gnt || p1_gnt) begin
        grants++;
        if (grants == 3) req[0] = 1'b0;
        if (grants == 4) req[1] = 1'b0;
      end
    end
    req = 2'b00;
    chk("contention_grants", grants, 32'd4);
    repeat (2) @(negedge clk);

    // Write then read back on p0
    do_txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    do_txn(0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Out-of-range write on p1, then addr 0 must be untouched
    do_txn(1, 1'b1, 32'd1024, 32'h1, 32'd0, 1'b1, 1'b0);
    do_txn(1, 1'b0, 32'd0, 32'd0, 32'h0000_1234, 1'b0, 1'b0);

    // p1 pulses req for one cycle during p0's RESP: must be ignored
    do_txn(0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    p1_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (p1_gnt) p1_seen++;
    end
    chk("ignored_p1_req", p1_seen, 32'd0);

    // Reset pulsed in ACCESS of a write: nothing commits, no response
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    we[0] = 1'b1; addr[0] = 32'd7; wdata[0] = 32'hA5; req[0] = 1'b1;
    exp_gnt.push_back(0);
    @(negedge clk);
    chk("abort_gnt", {31'b0, p0_gnt}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ram_we", {31'b0, ram_write_enable}, 32'd0);
    chk("abort_gnt_dropped", {31'b0, p0_gnt}, 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    do_txn(0, 1'b0, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);

    // Idle for 10 cycles
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_ram_en", {30'b0, ram_write_enable, ram_read_enable}, 32'd0);
      chk("idle_ram_addr", ram_addr, 32'd0);
    end

    chk("pending_p0", exp_q0.size(), 32'd0);
    chk("pending_p1", exp_q1.size(), 32'd0);
    chk("pending_gnt", exp_gnt.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
